// File: rtl/serial_rx_8x_pkg.sv
// Shared constants, rx state encoding and vote helper for the 8x-oversampled
// serial receiver.
package serial_rx_8x_pkg;

    localparam int UART_BITS  = 8;
    localparam int OVERSAMPLE = 8;

    localparam logic [2:0] SAMPLE_TICK_A = 3'd3;
    localparam logic [2:0] SAMPLE_TICK_B = 3'd4;
    localparam logic [2:0] SAMPLE_TICK_C = 3'd5;
    localparam logic [2:0] CTR_LAST      = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT      = 3'(UART_BITS - 1);

    typedef enum logic [2:0] {
        RX_WAIT_HIGH = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_STOP      = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Small synchronous FIFO for received bytes; head and empty are registered so
// a pushed byte appears exactly one clk after the push.
module serial_rx_fifo #(
    parameter int FIFO_LOG2 = 2,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [FIFO_LOG2:0]   wr_r, rd_r, wr_s, rd_s, occ_s;
    logic [FIFO_LOG2-1:0] rd_next_idx_s;
    logic [WIDTH-1:0]     head_r, head_s;
    logic                 empty_r;
    logic                 full_s, empty_s, do_push_s, do_pop_s;

    assign full_s  = (wr_r[FIFO_LOG2] != rd_r[FIFO_LOG2]) &&
                     (wr_r[FIFO_LOG2-1:0] == rd_r[FIFO_LOG2-1:0]);
    assign empty_s = (wr_r == rd_r);
    assign full    = full_s;
    assign empty   = empty_r;
    assign head    = head_r;

    // Next pointers and next head value; a pop while full frees the slot the push uses.
    always_comb begin
        do_pop_s      = pop & ~empty_s;
        do_push_s     = push & (~full_s | do_pop_s);
        occ_s         = wr_r - rd_r;
        rd_next_idx_s = rd_r[FIFO_LOG2-1:0] + {{(FIFO_LOG2-1){1'b0}}, 1'b1};
        wr_s          = do_push_s ? (wr_r + {{FIFO_LOG2{1'b0}}, 1'b1}) : wr_r;
        rd_s          = do_pop_s  ? (rd_r + {{FIFO_LOG2{1'b0}}, 1'b1}) : rd_r;
        head_s        = head_r;
        if (do_pop_s) begin
            if (occ_s > {{FIFO_LOG2{1'b0}}, 1'b1}) begin
                head_s = mem_r[rd_next_idx_s];
            end else if (do_push_s) begin
                head_s = din;
            end else begin
                head_s = head_r;
            end
        end else if (empty_s && do_push_s) begin
            head_s = din;
        end else begin
            head_s = head_r;
        end
    end

    // Pointer, head and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r    <= '0;
            rd_r    <= '0;
            head_r  <= '0;
            empty_r <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            wr_r    <= wr_s;
            rd_r    <= rd_s;
            head_r  <= head_s;
            empty_r <= (wr_s == rd_s);
            if (do_push_s) begin
                mem_r[wr_r[FIFO_LOG2-1:0]] <= din;
            end
        end
    end

endmodule

// File: rtl/serial_rx_8x.sv
// 8N1 receiver: rxd synchroniser, 8x-oversampled framing FSM with 3-sample
// majority vote, byte FIFO and sticky framing/overrun flags.
module serial_rx_8x
    import serial_rx_8x_pkg::*;
#(
    parameter int FIFO_LOG2   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud8,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_frame,
    output logic       err_ovr,
    input  logic       err_clr
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxd_s;
    rx_state_t              state_r, state_s;
    logic [2:0]             ctr_r, ctr_s, bit_r, bit_s;
    logic [1:0]             samp_r, samp_s;
    logic [7:0]             shift_r, shift_s;
    logic                   vote_s, push_s, frame_err_s, ovr_s;
    logic                   fifo_full_s, fifo_empty_s;
    logic                   err_frame_r, err_ovr_r;

    assign rxd_s = sync_r[SYNC_STAGES-1];

    // rxd synchroniser, idles high through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rxd};
        end
    end

    // Framing FSM next state; everything advances only on baud8 ticks.
    always_comb begin
        state_s     = state_r;
        ctr_s       = ctr_r;
        bit_s       = bit_r;
        samp_s      = samp_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        vote_s      = majority3(samp_r[0], samp_r[1], rxd_s);
        if (baud8) begin
            ctr_s = ctr_r + 3'd1;
            if (ctr_r == SAMPLE_TICK_A) begin
                samp_s[0] = rxd_s;
            end else if (ctr_r == SAMPLE_TICK_B) begin
                samp_s[1] = rxd_s;
            end else begin
                samp_s = samp_r;
            end
            case (state_r)
                RX_WAIT_HIGH: begin
                    ctr_s   = 3'd0;
                    state_s = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
                end
                RX_IDLE: begin
                    // The detecting tick is count 0 of the start bit.
                    ctr_s   = rxd_s ? 3'd0 : 3'd1;
                    state_s = rxd_s ? RX_IDLE : RX_START;
                end
                RX_START: begin
                    if ((ctr_r == SAMPLE_TICK_C) && vote_s) begin
                        state_s = RX_IDLE;
                        ctr_s   = 3'd0;
                    end else if (ctr_r == CTR_LAST) begin
                        state_s = RX_DATA;
                        bit_s   = 3'd0;
                    end else begin
                        state_s = RX_START;
                    end
                end
                RX_DATA: begin
                    if (ctr_r == SAMPLE_TICK_C) begin
                        shift_s = {vote_s, shift_r[7:1]};
                    end else begin
                        shift_s = shift_r;
                    end
                    if (ctr_r == CTR_LAST) begin
                        if (bit_r == LAST_BIT) begin
                            state_s = RX_STOP;
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        bit_s = bit_r;
                    end
                end
                RX_STOP: begin
                    if (ctr_r == SAMPLE_TICK_C) begin
                        ctr_s       = 3'd0;
                        push_s      = vote_s;
                        frame_err_s = ~vote_s;
                        state_s     = vote_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        state_s = RX_STOP;
                    end
                end
                default: begin
                    state_s = RX_WAIT_HIGH;
                    ctr_s   = 3'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Framing FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_WAIT_HIGH;
            ctr_r   <= 3'd0;
            bit_r   <= 3'd0;
            samp_r  <= 2'b11;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_s;
            ctr_r   <= ctr_s;
            bit_r   <= bit_s;
            samp_r  <= samp_s;
            shift_r <= shift_s;
        end
    end

    serial_rx_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (shift_r),
        .pop   (rx_ready),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (rx_data)
    );

    assign rx_valid = ~fifo_empty_s;
    assign ovr_s    = push_s & fifo_full_s & ~(rx_ready & ~fifo_empty_s);

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_frame_r <= 1'b0;
            err_ovr_r   <= 1'b0;
        end else begin
            if (frame_err_s) begin
                err_frame_r <= 1'b1;
            end else if (err_clr) begin
                err_frame_r <= 1'b0;
            end
            if (ovr_s) begin
                err_ovr_r <= 1'b1;
            end else if (err_clr) begin
                err_ovr_r <= 1'b0;
            end
        end
    end

    assign err_frame = err_frame_r;
    assign err_ovr   = err_ovr_r;

endmodule

// File: tb/tb_serial_rx_8x.sv
// Directed plus random frames against a queue-based model of the receiver.
module tb_serial_rx_8x;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud8 = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, err_frame, err_ovr;

    int         n_checks = 0;
    int         n_fails = 0;
    int         div = 0;
    logic [7:0] exp_q[$];
    logic       exp_frame = 1'b0;
    logic       exp_ovr = 1'b0;

    serial_rx_8x #(.FIFO_LOG2(2), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud8     (baud8),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_frame (err_frame),
        .err_ovr   (err_ovr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div == 69) begin
            div   <= 0;
            baud8 <= 1'b1;
        end else begin
            div   <= div + 1;
            baud8 <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Leaves the bench at the negedge just before the n-th next tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (baud8 !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rxd = v;
        wait_ticks(n);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() >= 4) exp_ovr = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_ticks);
        send_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) send_bit(b[i], 8);
        send_bit(stop, stop_ticks);
        if (stop) model_push(b);
        else exp_frame = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame"}, {7'd0, err_frame}, {7'd0, exp_frame});
        check({tag, "_ovr"}, {7'd0, err_ovr}, {7'd0, exp_ovr});
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, {7'd0, rx_valid}, 8'd1);
        check({tag, "_data"}, rx_data, exp_q[0]);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        check({tag, "_empty"}, {7'd0, rx_valid}, 8'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_frame = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] first6;

        repeat (5) @(negedge clk);
        check("rst_valid", {7'd0, rx_valid}, 8'd0);
        check("rst_data", rx_data, 8'h00);
        check_flags("rst");
        rst_n = 1'b1;
        send_bit(1'b1, 10);

        // Single byte with exact push-latency probe on the stop sample tick.
        b = 8'hA5;
        send_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) send_bit(b[i], 8);
        rxd = 1'b1;
        wait_ticks(6);
        check("a5_prepush", {7'd0, rx_valid}, 8'd0);
        @(negedge clk);
        check("a5_lat_valid", {7'd0, rx_valid}, 8'd1);
        check("a5_lat_data", rx_data, 8'hA5);
        model_push(b);
        wait_ticks(2);
        send_bit(1'b1, 10);
        check_flags("a5");
        drain("a5");

        // Back-to-back frames with shortened stop bits.
        send_frame(8'h00, 1'b1, 7);
        send_frame(8'hFF, 1'b1, 7);
        send_frame(8'h55, 1'b1, 8);
        send_bit(1'b1, 10);
        check_flags("b2b");
        drain("b2b");

        // Start-bit glitch is rejected, then a normal byte.
        send_bit(1'b0, 2);
        send_bit(1'b1, 12);
        check("glitch_empty", {7'd0, rx_valid}, 8'd0);
        send_frame(8'h3C, 1'b1, 8);
        send_bit(1'b1, 10);
        check_flags("glitch");
        drain("glitch");

        // Framing error, break, recovery, clear.
        send_frame(8'h81, 1'b0, 8);
        send_bit(1'b0, 12);
        send_bit(1'b1, 10);
        check("ferr_empty", {7'd0, rx_valid}, 8'd0);
        send_frame(8'h42, 1'b1, 8);
        send_bit(1'b1, 10);
        check_flags("ferr");
        drain("ferr");
        pulse_clr();
        check_flags("ferr_clr");

        // Overrun, then pop coinciding with the push into a full FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 8);
        send_bit(1'b1, 10);
        check_flags("ovr");
        pulse_clr();
        check_flags("ovr_clr");
        b = 8'h06;
        send_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) send_bit(b[i], 8);
        rxd = 1'b1;
        wait_ticks(6);
        first6 = exp_q[0];
        check("popfull_head", rx_data, first6);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(b);
        wait_ticks(2);
        send_bit(1'b1, 5);
        check_flags("popfull");
        drain("popfull");

        // Reset in the middle of a frame while rxd is low.
        b = 8'h77;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(b[i], 8);
        rxd = b[4];
        wait_ticks(3);
        @(negedge clk);
        rst_n = 1'b0;
        rxd   = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete();
        exp_frame = 1'b0;
        exp_ovr   = 1'b0;
        rst_n = 1'b1;
        send_bit(1'b0, 12);
        send_bit(1'b1, 10);
        check("rstmid_empty", {7'd0, rx_valid}, 8'd0);
        check_flags("rstmid");
        send_frame(8'h12, 1'b1, 8);
        send_bit(1'b1, 10);
        drain("rstmid");

        // Random bytes with random idle gaps.
        for (int k = 0; k < 10; k++) begin
            send_bit(1'b1, $urandom_range(1, 4));
            send_frame(8'($urandom), 1'b1, 8);
            pop_check("rand");
        end
        send_bit(1'b1, 4);
        check_flags("rand");
        check("rand_empty", {7'd0, rx_valid}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
